// File: rtl/tracer_frame_buffer_if.sv
// Pixel write, display read and frame-status signals shared by the tracer host,
// the display scan-out and the double-buffered frame store.
interface tracer_frame_buffer_if #(
  parameter int COL_W = 7,
  parameter int ROW_W = 6,
  parameter int PIX_W = 12
);
  logic             wr_valid;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [PIX_W-1:0] wr_data;
  logic             wr_ready;
  logic             rd_en;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             vsync;
  logic             front_sel;
  logic             frame_done;
  logic             overrun;
  logic [7:0]       repeat_cnt;

  modport master (
    output wr_valid, wr_col, wr_row, wr_data, rd_en, rd_col, rd_row, vsync,
    input  wr_ready, rd_data, rd_valid, front_sel, frame_done, overrun, repeat_cnt
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_data, rd_en, rd_col, rd_row, vsync,
    output wr_ready, rd_data, rd_valid, front_sel, frame_done, overrun, repeat_cnt
  );
endinterface

// File: rtl/tracer_frame_buffer.sv
// Double-buffered pixel store: the tracer fills the back bank while the display
// reads the front bank; banks swap on vsync only once the back frame is complete.
module tracer_frame_buffer #(
  parameter int COL_W = 7,
  parameter int ROW_W = 6,
  parameter int PIX_W = 12
) (
  input  logic                  tracer_clk,
  input  logic                  rst,
  tracer_frame_buffer_if.slave  bus
);

  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {FILL, WAIT_SWAP} state_t;

  state_t            state, state_nxt;
  logic              wr_ready_c;
  logic              wr_fire;
  logic              last_px;
  logic              swap;
  logic              front_sel;
  logic              frame_done;
  logic              overrun;
  logic [7:0]        repeat_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data_p1;
  logic              vld_p1;

  logic [PIX_W-1:0]  bank0 [DEPTH];
  logic [PIX_W-1:0]  bank1 [DEPTH];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wr_addr = {bus.wr_row, bus.wr_col};
  assign rd_addr = {bus.rd_row, bus.rd_col};
  assign last_px = (&bus.wr_col) && (&bus.wr_row);

  always_ff @(posedge tracer_clk) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:      if (wr_fire && last_px) state_nxt = WAIT_SWAP;
      WAIT_SWAP: if (bus.vsync)          state_nxt = FILL;
      default:                           state_nxt = FILL;
    endcase
  end

  // A write is gated off during reset so an abandoned frame cannot leak into a bank.
  always_comb begin
    wr_ready_c = (state == FILL);
    wr_fire    = rst && bus.wr_valid && wr_ready_c;
    swap       = (state == WAIT_SWAP) && bus.vsync;
  end

  // Stage boundary: frame control registers
  always_ff @(posedge tracer_clk) begin
    if (!rst) begin
      front_sel  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      repeat_cnt <= 8'd0;
    end else begin
      frame_done <= swap;
      if (swap)                               front_sel  <= ~front_sel;
      if (bus.wr_valid && !wr_ready_c)        overrun    <= 1'b1;
      if (bus.vsync && !swap)                 repeat_cnt <= sat_inc8(repeat_cnt);
    end
  end

  // The back bank is always the one not being displayed.
  always_ff @(posedge tracer_clk) begin
    if (wr_fire && front_sel) bank0[wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge tracer_clk) begin
    if (wr_fire && !front_sel) bank1[wr_addr] <= bus.wr_data;
  end

  // Stage boundary: read port, one cycle of latency
  always_ff @(posedge tracer_clk) begin
    if (!rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= bus.rd_en;
      if (bus.rd_en) rd_data_p1 <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

  assign bus.wr_ready   = wr_ready_c;
  assign bus.rd_data    = rd_data_p1;
  assign bus.rd_valid   = vld_p1;
  assign bus.front_sel  = front_sel;
  assign bus.frame_done = frame_done;
  assign bus.overrun    = overrun;
  assign bus.repeat_cnt = repeat_cnt;

endmodule

// File: tb/tb_tracer_frame_buffer.sv
// Directed bench for tracer_frame_buffer: fill/swap, vsync repeat counting,
// overrun, last-pixel/vsync collision, read across swap and mid-frame reset.
module tb_tracer_frame_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  tracer_frame_buffer_if #(.COL_W(7), .ROW_W(6), .PIX_W(12)) bus ();

  tracer_frame_buffer #(.COL_W(7), .ROW_W(6), .PIX_W(12)) dut (
    .tracer_clk (clk),
    .rst        (rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input int col, input int row, input logic [11:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_col   = 7'(col);
    bus.wr_row   = 6'(row);
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_px(input int col, input int row);
    bus.rd_en  = 1'b1;
    bus.rd_col = 7'(col);
    bus.rd_row = 6'(row);
    tick();
    bus.rd_en  = 1'b0;
  endtask

  task automatic vsync_pulse();
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
  endtask

  // Writes pixels 0..npix-1 in address order; data is addr[11:0], optionally inverted.
  task automatic write_frame(input logic inv, input int npix);
    for (int a = 0; a < npix; a++) begin
      logic [12:0] ad;
      ad           = 13'(a);
      bus.wr_valid = 1'b1;
      bus.wr_col   = ad[6:0];
      bus.wr_row   = ad[12:7];
      bus.wr_data  = inv ? ~ad[11:0] : ad[11:0];
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%0h exp=1", bus.wr_ready); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL rst_front_sel got=%0h exp=0", bus.front_sel); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0h exp=0", bus.rd_valid); end
    total++; if (bus.rd_data !== 12'h000) begin bad++; $display("FAIL rst_rd_data got=%0h exp=0", bus.rd_data); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%0h exp=0", bus.frame_done); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0h exp=0", bus.overrun); end
    total++; if (bus.repeat_cnt !== 8'd0) begin bad++; $display("FAIL rst_repeat_cnt got=%0d exp=0", bus.repeat_cnt); end
  endtask

  task automatic test_fill_swap();
    write_frame(1'b0, 8191);
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_before_last got=%0h exp=1", bus.wr_ready); end
    wr_px(127, 63, 12'hFFF);
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_after_last got=%0h exp=0", bus.wr_ready); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL fill_front_before_vsync got=%0h exp=0", bus.front_sel); end
    vsync_pulse();
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL swap_front_sel got=%0h exp=1", bus.front_sel); end
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL swap_frame_done got=%0h exp=1", bus.frame_done); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL swap_wr_ready got=%0h exp=1", bus.wr_ready); end
    total++; if (bus.repeat_cnt !== 8'd0) begin bad++; $display("FAIL swap_repeat_cnt got=%0d exp=0", bus.repeat_cnt); end
    tick();
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL swap_frame_done_pulse got=%0h exp=0", bus.frame_done); end
    rd_px(5, 3);
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%0h exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 12'h185) begin bad++; $display("FAIL rd_5_3 got=%0h exp=185", bus.rd_data); end
    tick();
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%0h exp=0", bus.rd_valid); end
    total++; if (bus.rd_data !== 12'h185) begin bad++; $display("FAIL rd_data_hold got=%0h exp=185", bus.rd_data); end
    rd_px(0, 40);
    total++; if (bus.rd_data !== 12'h400) begin bad++; $display("FAIL rd_0_40 got=%0h exp=400", bus.rd_data); end
  endtask

  task automatic test_repeat();
    wr_px(10, 10, 12'h0AA);
    for (int i = 0; i < 3; i++) vsync_pulse();
    total++; if (bus.repeat_cnt !== 8'd3) begin bad++; $display("FAIL repeat_3 got=%0d exp=3", bus.repeat_cnt); end
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL repeat_front_sel got=%0h exp=1", bus.front_sel); end
    for (int i = 0; i < 251; i++) vsync_pulse();
    total++; if (bus.repeat_cnt !== 8'd254) begin bad++; $display("FAIL repeat_254 got=%0d exp=254", bus.repeat_cnt); end
    for (int i = 0; i < 6; i++) vsync_pulse();
    total++; if (bus.repeat_cnt !== 8'd255) begin bad++; $display("FAIL repeat_sat got=%0d exp=255", bus.repeat_cnt); end
  endtask

  task automatic test_overrun();
    wr_px(0, 0, 12'h123);
    wr_px(127, 63, 12'hABC);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_before got=%0h exp=0", bus.overrun); end
    wr_px(0, 0, 12'hFFF);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0h exp=1", bus.overrun); end
    vsync_pulse();
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL ovr_swap_front got=%0h exp=0", bus.front_sel); end
    total++; if (bus.repeat_cnt !== 8'd255) begin bad++; $display("FAIL ovr_swap_repeat got=%0d exp=255", bus.repeat_cnt); end
    rd_px(0, 0);
    total++; if (bus.rd_data !== 12'h123) begin bad++; $display("FAIL ovr_dropped_write got=%0h exp=123", bus.rd_data); end
    rd_px(127, 63);
    total++; if (bus.rd_data !== 12'hABC) begin bad++; $display("FAIL ovr_last_px got=%0h exp=abc", bus.rd_data); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0h exp=1", bus.overrun); end
    do_reset();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_cleared got=%0h exp=0", bus.overrun); end
    total++; if (bus.repeat_cnt !== 8'd0) begin bad++; $display("FAIL ovr_rst_repeat got=%0d exp=0", bus.repeat_cnt); end
  endtask

  task automatic test_last_px_vsync();
    bus.vsync = 1'b1;
    wr_px(127, 63, 12'h5A5);
    bus.vsync = 1'b0;
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL coll_wr_ready got=%0h exp=0", bus.wr_ready); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL coll_no_swap got=%0h exp=0", bus.front_sel); end
    total++; if (bus.repeat_cnt !== 8'd1) begin bad++; $display("FAIL coll_repeat got=%0d exp=1", bus.repeat_cnt); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL coll_frame_done got=%0h exp=0", bus.frame_done); end
    vsync_pulse();
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL coll_swap got=%0h exp=1", bus.front_sel); end
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL coll_swap_done got=%0h exp=1", bus.frame_done); end
    total++; if (bus.repeat_cnt !== 8'd1) begin bad++; $display("FAIL coll_swap_repeat got=%0d exp=1", bus.repeat_cnt); end
    rd_px(127, 63);
    total++; if (bus.rd_data !== 12'h5A5) begin bad++; $display("FAIL coll_rd_last got=%0h exp=5a5", bus.rd_data); end
    rd_px(5, 3);
    total++; if (bus.rd_data !== 12'h185) begin bad++; $display("FAIL coll_rd_5_3 got=%0h exp=185", bus.rd_data); end
  endtask

  task automatic test_read_across_swap();
    wr_px(7, 2, 12'h777);
    wr_px(127, 63, 12'h321);
    bus.rd_en  = 1'b1;
    bus.rd_col = 7'd7;
    bus.rd_row = 6'd2;
    bus.vsync  = 1'b1;
    tick();
    bus.vsync  = 1'b0;
    total++; if (bus.rd_data !== 12'h107) begin bad++; $display("FAIL xswap_old_front got=%0h exp=107", bus.rd_data); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL xswap_front got=%0h exp=0", bus.front_sel); end
    tick();
    bus.rd_en  = 1'b0;
    total++; if (bus.rd_data !== 12'h777) begin bad++; $display("FAIL xswap_new_front got=%0h exp=777", bus.rd_data); end
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL xswap_rd_valid got=%0h exp=1", bus.rd_valid); end
  endtask

  task automatic test_mid_reset();
    wr_px(127, 63, 12'h001);
    vsync_pulse();
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL mrst_pre_front got=%0h exp=1", bus.front_sel); end
    write_frame(1'b1, 4000);
    vsync_pulse();
    do_reset();
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL mrst_front got=%0h exp=0", bus.front_sel); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL mrst_wr_ready got=%0h exp=1", bus.wr_ready); end
    total++; if (bus.repeat_cnt !== 8'd0) begin bad++; $display("FAIL mrst_repeat got=%0d exp=0", bus.repeat_cnt); end
    write_frame(1'b1, 8192);
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL mrst_full_ready got=%0h exp=0", bus.wr_ready); end
    vsync_pulse();
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL mrst_swap got=%0h exp=1", bus.front_sel); end
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL mrst_frame_done got=%0h exp=1", bus.frame_done); end
    rd_px(5, 3);
    total++; if (bus.rd_data !== 12'hE7A) begin bad++; $display("FAIL mrst_rd_5_3 got=%0h exp=e7a", bus.rd_data); end
    rd_px(0, 0);
    total++; if (bus.rd_data !== 12'hFFF) begin bad++; $display("FAIL mrst_rd_0_0 got=%0h exp=fff", bus.rd_data); end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_col   = '0;
    bus.wr_row   = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_col   = '0;
    bus.rd_row   = '0;
    bus.vsync    = 1'b0;
    test_reset();
    test_fill_swap();
    test_repeat();
    test_overrun();
    test_last_px_vsync();
    test_read_across_swap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
